// File: rtl/ifetch_queue.sv
// Instruction fetch stage: issues single-outstanding word fetches for the current PC
// and buffers returned instructions, with their PCs, in a small queue for the decoder.
module ifetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        pc_advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_misaligned
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          outstanding;
  logic          discard;
  logic          misaligned;
  logic [31:0]   out_pc;

  logic          pop;
  logic          resp;
  logic          push;
  logic          pc_aligned;
  logic          credit_ok;
  logic          eligible;
  logic [CW-1:0] credit_used;

  // Credit counts the in-flight word as already occupying a slot, so a grant
  // can never produce a response with nowhere to go.
  always_comb begin
    pop         = instr_valid & instr_ready;
    resp        = imem_rvalid & outstanding;
    push        = resp & ~discard & ~flush;
    credit_used = CW'(count) + CW'(outstanding) - CW'(pop);
    credit_ok   = credit_used < DEPTH_C;
    pc_aligned  = pc[1:0] == 2'b00;
    eligible    = ~rst & ~flush & ~misaligned & (~outstanding | imem_rvalid) & credit_ok;
    imem_req    = eligible & pc_aligned;
    pc_advance  = imem_req & imem_gnt;
    imem_addr   = rst ? 32'h0 : {pc[31:2], 2'b00};
  end

  assign instr_valid      = count != '0;
  assign instr            = q_instr[rd_ptr];
  assign instr_pc         = q_pc[rd_ptr];
  assign fetch_misaligned = misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= out_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A flush with a word still in flight marks that word to be dropped on arrival;
  // a word arriving in the flush cycle itself is dropped through push instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= 1'b0;
      discard     <= 1'b0;
      misaligned  <= 1'b0;
      out_pc      <= '0;
    end else begin
      if (pc_advance) begin
        outstanding <= 1'b1;
        out_pc      <= pc;
      end else if (resp) begin
        outstanding <= 1'b0;
      end

      if (flush)               discard <= outstanding & ~imem_rvalid;
      else if (resp & discard) discard <= 1'b0;

      if (flush)                         misaligned <= 1'b0;
      else if (eligible & ~pc_aligned)   misaligned <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed cycles push expected {instr, pc} pairs
// and per-cycle output expectations; a negedge monitor compares everything.
module tb_ifetch_queue;

  localparam logic [31:0] XOR_KEY = 32'hA5A5A5A5;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        flush;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_misaligned;

  ifetch_queue #(.DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc               (pc),
    .flush            (flush),
    .pc_advance       (pc_advance),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_ready      (instr_ready),
    .fetch_misaligned (fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t mon_e;

  int checks;
  int failures;

  logic auto_mem;
  logic auto_pc;

  logic chk_req, chk_adv, chk_addr, chk_valid, chk_mis, chk_zero, chk_head, end_check;
  logic exp_req, exp_adv, exp_valid, exp_mis;
  logic [31:0] exp_addr, exp_head_instr, exp_head_pc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: owns all counters; compares flagged expectations and the scoreboard.
  initial begin
    checks   = 0;
    failures = 0;
    forever begin
      @(negedge clk);
      if (chk_req)   checkOutput("imem_req", 32'(imem_req), 32'(exp_req));
      if (chk_adv)   checkOutput("pc_advance", 32'(pc_advance), 32'(exp_adv));
      if (chk_addr)  checkOutput("imem_addr", imem_addr, exp_addr);
      if (chk_valid) checkOutput("instr_valid", 32'(instr_valid), 32'(exp_valid));
      if (chk_mis)   checkOutput("fetch_misaligned", 32'(fetch_misaligned), 32'(exp_mis));
      if (chk_zero) begin
        checkOutput("instr_in_reset", instr, 32'h0);
        checkOutput("instr_pc_in_reset", instr_pc, 32'h0);
      end
      if (chk_head) begin
        checkOutput("head_instr", instr, exp_head_instr);
        checkOutput("head_pc", instr_pc, exp_head_pc);
      end
      if (instr_valid && instr_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL sb_unexpected actual instr=0x%08h pc=0x%08h required none", instr, instr_pc);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("sb_instr", instr, mon_e.instr);
          checkOutput("sb_pc", instr_pc, mon_e.pc);
        end
      end
      if (end_check) checkOutput("sb_leftover", 32'(sb.size()), 32'h0);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one cycle: memory answers a grant one cycle later, PC moves on pc_advance.
  task automatic applyStimulus();
    logic        adv_s;
    logic [31:0] addr_s;
    @(negedge clk);
    adv_s  = pc_advance;
    addr_s = imem_addr;
    @(posedge clk);
    #1;
    chk_req = 0; chk_adv = 0; chk_addr = 0; chk_valid = 0;
    chk_mis = 0; chk_zero = 0; chk_head = 0; end_check = 0;
    if (auto_mem) begin
      imem_rvalid = adv_s;
      imem_rdata  = addr_s ^ XOR_KEY;
    end
    if (auto_pc && adv_s) pc = pc + 32'd4;
  endtask

  task automatic push_exp(input logic [31:0] p);
    sb_entry_t e;
    e.instr = p ^ XOR_KEY;
    e.pc    = p;
    sb.push_back(e);
  endtask

  task automatic exp_fetch(input logic req, input logic adv);
    chk_req = 1; exp_req = req;
    chk_adv = 1; exp_adv = adv;
  endtask

  task automatic exp_addr_is(input logic [31:0] a);
    chk_addr = 1; exp_addr = a;
  endtask

  task automatic exp_valid_is(input logic v);
    chk_valid = 1; exp_valid = v;
  endtask

  task automatic exp_mis_is(input logic m);
    chk_mis = 1; exp_mis = m;
  endtask

  task automatic exp_head(input logic [31:0] p);
    chk_head = 1; exp_head_pc = p; exp_head_instr = p ^ XOR_KEY;
  endtask

  task automatic exp_all_zero();
    exp_fetch(0, 0);
    exp_addr_is(32'h0);
    exp_valid_is(0);
    exp_mis_is(0);
    chk_zero = 1;
  endtask

  initial begin
    chk_req = 0; chk_adv = 0; chk_addr = 0; chk_valid = 0;
    chk_mis = 0; chk_zero = 0; chk_head = 0; end_check = 0;
    exp_req = 0; exp_adv = 0; exp_valid = 0; exp_mis = 0;
    exp_addr = 0; exp_head_instr = 0; exp_head_pc = 0;
    auto_mem = 1; auto_pc = 1;
    rst = 1; pc = 32'h100; flush = 0; imem_gnt = 1;
    imem_rvalid = 0; imem_rdata = 0; instr_ready = 1;
    exp_all_zero();

    // Release reset; idle cycle with grant withheld.
    applyStimulus();
    rst = 0; pc = 32'h0; imem_gnt = 0;
    exp_fetch(1, 0);
    exp_addr_is(32'h0);
    exp_mis_is(0);

    // Streaming: eight back-to-back fetches, one instruction per cycle from cycle 2.
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      imem_gnt = (i < 8);
      if (i < 8) begin
        exp_fetch(1, 1);
        exp_addr_is(32'(i * 4));
      end
      if (i >= 2) exp_valid_is(1);
    end

    // Backpressure: queue fills to two, requests stop, resume the cycle ready rises.
    push_exp(32'h20); push_exp(32'h24); push_exp(32'h28); push_exp(32'h2C);
    for (int j = 0; j < 10; j++) begin
      applyStimulus();
      instr_ready = (j >= 5);
      imem_gnt    = (j <= 6);
      if (j <= 6) exp_fetch(j < 2 || j >= 5, j < 2 || j >= 5);
      if (j == 3 || j == 4) exp_valid_is(1);
      if (j == 4) exp_head(32'h20);
      if (j == 5) exp_addr_is(32'h28);
      if (j == 9) exp_valid_is(0);
    end

    // Grant stall: request held at 0x10 for three cycles, granted on the fourth.
    push_exp(32'h10);
    for (int s = 0; s < 7; s++) begin
      applyStimulus();
      if (s == 0) pc = 32'h10;
      imem_gnt = (s == 3);
      if (s <= 3) begin
        exp_fetch(1, s == 3);
        exp_addr_is(32'h10);
      end
      if (s == 5) exp_valid_is(1);
      if (s == 6) exp_valid_is(0);
    end

    // Flush with a fetch in flight: the late 0xDEAD word must never reach the queue.
    applyStimulus();
    auto_mem = 0; imem_rvalid = 0; pc = 32'h20; imem_gnt = 1;
    exp_fetch(1, 1); exp_addr_is(32'h20);
    applyStimulus();
    pc = 32'h80; flush = 1; imem_gnt = 1;
    exp_fetch(0, 0);
    applyStimulus();
    flush = 0; imem_gnt = 1;
    exp_fetch(0, 0); exp_valid_is(0);
    applyStimulus();
    imem_rvalid = 1; imem_rdata = 32'h0000DEAD; imem_gnt = 0;
    exp_fetch(1, 0); exp_valid_is(0);
    push_exp(32'h80);
    applyStimulus();
    imem_rvalid = 0; imem_gnt = 1;
    exp_fetch(1, 1); exp_addr_is(32'h80); exp_valid_is(0);
    auto_mem = 1;
    applyStimulus();
    imem_gnt = 0;
    exp_valid_is(0);
    applyStimulus();
    exp_valid_is(1); exp_head(32'h80);

    // Misaligned PC: flag sets, requests stop, queued entries drain, flush recovers.
    push_exp(32'h100); push_exp(32'h104); push_exp(32'h40);
    for (int m = 0; m < 10; m++) begin
      applyStimulus();
      case (m)
        0: begin pc = 32'h100; imem_gnt = 1; instr_ready = 0; exp_fetch(1, 1); end
        1: begin exp_fetch(1, 1); exp_addr_is(32'h104); end
        2: exp_fetch(0, 0);
        3: begin pc = 32'h22; instr_ready = 1; exp_fetch(0, 0); exp_mis_is(0); exp_head(32'h100); end
        4: begin exp_fetch(0, 0); exp_mis_is(1); exp_valid_is(1); end
        5: begin exp_fetch(0, 0); exp_mis_is(1); exp_valid_is(0); end
        6: begin flush = 1; pc = 32'h40; exp_fetch(0, 0); exp_mis_is(1); end
        7: begin flush = 0; exp_fetch(1, 1); exp_addr_is(32'h40); exp_mis_is(0); end
        8: imem_gnt = 0;
        default: exp_valid_is(1);
      endcase
    end

    // Asynchronous reset mid-stream, then a stale response after release.
    push_exp(32'h200);
    applyStimulus();
    pc = 32'h200; imem_gnt = 1;
    exp_fetch(1, 1);
    applyStimulus();
    exp_fetch(1, 1);
    applyStimulus();
    exp_fetch(1, 1); exp_head(32'h200);
    applyStimulus();
    #2;
    rst = 1;
    exp_all_zero();
    applyStimulus();
    auto_mem = 0; imem_gnt = 0;
    exp_all_zero();
    applyStimulus();
    rst = 0; imem_rvalid = 1; imem_rdata = 32'h00000BAD;
    exp_valid_is(0); exp_fetch(1, 0);
    applyStimulus();
    imem_rvalid = 0;
    exp_valid_is(0);
    applyStimulus();
    exp_valid_is(0);
    end_check = 1;

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch stage directly downstream of the program-counter register. Takes the current PC, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned instructions in a small queue for the decoder. Drives `pc_advance` back to the next-PC mux so the PC register moves only when a fetch has been accepted. Handles redirect flushes and misaligned PCs.

## Interface
- `DEPTH`, 2: instruction queue entries; power of two, 2..8.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  32  fetch address from the PC register.
- `flush`  in  1  redirect; discard queued and in-flight instructions.
- `pc_advance`  out  1  fetch for `pc` accepted this cycle; next-PC mux selects the new PC, else holds.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word address, `{pc[31:2],2'b00}`.
- `imem_gnt`  in  1  request accepted.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  returned instruction word.
- `instr_valid`  out  1  queue head valid.
- `instr`  out  32  queue head instruction.
- `instr_pc`  out  32  PC of queue head.
- `instr_ready`  in  1  decoder consumes head when `instr_valid & instr_ready`.
- `fetch_misaligned`  out  1  sticky; `pc[1:0]!=0` was seen at request time.

## Operation
- State: queue (DEPTH x {instr, pc}), wr/rd pointers with count, `outstanding` bit, `out_pc` register, `discard` bit, `misaligned` bit.
- At most one outstanding request. Response arrives >=1 cycle after grant, in order.
- `imem_req = ~flush & ~misaligned & pc[1:0]==0 & (~outstanding | imem_rvalid) & (count + outstanding - pop < DEPTH)`, where `pop = instr_valid & instr_ready`. Credit check guarantees the queue never overflows.
- `pc_advance = imem_req & imem_gnt`. On grant: `outstanding<=1`, `out_pc<=pc`.
- `imem_req` is held with a stable address until granted, because `pc` only moves on `pc_advance`.
- Response: `imem_rvalid` with `outstanding=1` clears `outstanding` unless a new grant occurs the same cycle. If `discard=0`, push `{imem_rdata, out_pc}`. If `discard=1`, drop the word and clear `discard`.
- A push and a pop in the same cycle are both performed; count is unchanged.
- Flush: queue emptied (pointers and count reset). If a request is outstanding and no response arrives this cycle, set `discard`. A response arriving in the flush cycle is dropped. No request is issued in the flush cycle. `misaligned` is cleared.
- Misaligned: if `pc[1:0]!=0` while otherwise eligible to request, set `misaligned`. No further requests until flush. Already-queued instructions still drain.
- `imem_rvalid` with `outstanding=0` is ignored.

## Timing
- Reset (async assert, sync release): queue empty, `outstanding=0`, `discard=0`, `misaligned=0`. All outputs 0: `imem_req`, `pc_advance`, `instr_valid`, `instr`, `instr_pc`, `fetch_misaligned`. `imem_addr` follows `pc`, gated to 0 during reset.
- `instr`, `instr_pc`, `instr_valid` come from registers (queue storage and count). There is no combinational path from `imem_rdata` or `instr_ready` to them.
- `imem_req` and `pc_advance` are combinational from state, `pc`, `flush`, `imem_gnt`, `imem_rvalid`, `instr_ready`.
- Latency: grant in cycle N, rvalid in cycle N+1 gives `instr_valid` in cycle N+2.
- Throughput: 1 instr/cycle with 1-cycle memory and decoder always ready.
- Reset mid-operation: all state is lost immediately. A response arriving after reset release is ignored because `outstanding=0`.

## Test plan
- Streaming: `pc` 0x0,0x4,0x8… driven from `pc_advance`, gnt=1, 1-cycle rvalid with rdata=addr^0xA5A5A5A5, ready=1 -> instr/instr_pc pairs in order, one per cycle from cycle 2, `pc_advance` high every cycle.
- Backpressure: `instr_ready=0` with DEPTH=2 -> exactly 2 entries plus 0 outstanding, then `imem_req=0`. Raise ready -> `imem_req` reasserts the same cycle, no loss or duplication.
- Grant stall: gnt=0 for 3 cycles at pc=0x10 -> `imem_req=1`, `imem_addr=0x10`, `pc_advance=0` throughout. Grant on the 4th cycle -> single fetch of 0x10.
- Flush with in-flight: grant 0x20, flush next cycle before rvalid, rvalid 2 cycles later with 0xDEAD -> 0xDEAD is never presented, queue empty, next fetch at the new `pc` delivered normally.
- Misaligned: pc=0x22 -> `fetch_misaligned=1`, no `imem_req`, queued entries still drain. Flush with pc=0x40 -> flag clears and fetch resumes at 0x40.
- Async reset asserted mid-stream between clock edges -> all outputs 0 immediately. A late rvalid after release is ignored.
